// File: rtl/branch_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// branch_addr_pkg
// Shared definitions for the branch/immediate address generator:
//   ext_mode_e  - 2-bit immediate extension mode
//   *_DEF       - default widths for the common 16->32 configuration
//   wrap_f      - decides whether base+ext crossed the zero boundary
// -----------------------------------------------------------------------------
package branch_addr_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO    = 2'b00,  // zero-extend
    EXT_SIGN    = 2'b01,  // sign-extend
    EXT_SIGN_SH = 2'b10,  // sign-extend then shift left (word-aligned offset)
    EXT_HIGH    = 2'b11   // immediate placed in the top bits (LUI-style)
  } ext_mode_e;

  localparam int unsigned IMM_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned SHIFT_DEF  = 2;

  // Unsigned offsets wrap on carry out. Signed offsets wrap when a positive
  // offset carries, or a negative offset fails to carry (borrow through zero).
  function automatic logic wrap_f(input ext_mode_e mode, input logic ext_msb,
                                  input logic carry);
    logic w;
    case (mode)
      EXT_SIGN, EXT_SIGN_SH: w = ext_msb ? ~carry : carry;
      EXT_ZERO, EXT_HIGH:    w = carry;
      default:               w = carry;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/branch_addr_gen_imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Combinational immediate extender and base-address adder.
// Ports:
//   imm_i    [IMM_W]   immediate field
//   base_i   [DATA_W]  base address
//   mode_i   ext_mode_e extension mode
//   ext_o    [DATA_W]  extended immediate
//   target_o [DATA_W]  (base + ext) mod 2^DATA_W
//   wrap_o             address crossed the zero boundary
// -----------------------------------------------------------------------------
module imm_ext_core
  import branch_addr_pkg::*;
#(
  parameter int unsigned IMM_W  = IMM_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SHIFT  = SHIFT_DEF
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [DATA_W-1:0] base_i,
  input  ext_mode_e         mode_i,
  output logic [DATA_W-1:0] ext_o,
  output logic [DATA_W-1:0] target_o,
  output logic              wrap_o
);

  localparam int unsigned PAD_W = DATA_W - IMM_W;

  logic [DATA_W-1:0] zext_s;
  logic [DATA_W-1:0] sext_s;
  logic [DATA_W-1:0] ext_s;
  logic [DATA_W:0]   sum_s;

  assign zext_s = {{PAD_W{1'b0}}, imm_i};
  assign sext_s = {{PAD_W{imm_i[IMM_W-1]}}, imm_i};

  // Select the extension form for the requested mode.
  always_comb begin
    ext_s = zext_s;
    case (mode_i)
      EXT_ZERO:    ext_s = zext_s;
      EXT_SIGN:    ext_s = sext_s;
      // SHIFT is small enough that the shifted-out bits are all sign copies.
      EXT_SIGN_SH: ext_s = sext_s << SHIFT;
      EXT_HIGH:    ext_s = {imm_i, {PAD_W{1'b0}}};
      default:     ext_s = zext_s;
    endcase
  end

  // One extra bit keeps the carry out for the wrap decision.
  assign sum_s    = {1'b0, base_i} + {1'b0, ext_s};
  assign ext_o    = ext_s;
  assign target_o = sum_s[DATA_W-1:0];
  assign wrap_o   = wrap_f(mode_i, ext_s[DATA_W-1], sum_s[DATA_W]);

endmodule

// File: rtl/branch_addr_gen.sv
// -----------------------------------------------------------------------------
// branch_addr_gen
// Extends an immediate, adds it to a base address and returns the result
// through a one-stage valid/ready pipeline with a skid buffer.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync discard of held results)
//   in_valid_i / in_ready_o, in_imm_i, in_base_i, in_mode_i   request side
//   out_valid_o / out_ready_i, out_ext_o, out_target_o, out_wrap_o  result side
// R is the output register; K catches a request accepted while R is stalled.
// in_ready depends only on K's state, never combinationally on out_ready.
// -----------------------------------------------------------------------------
module branch_addr_gen
  import branch_addr_pkg::*;
#(
  parameter int unsigned IMM_W  = IMM_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SHIFT  = SHIFT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IMM_W-1:0]  in_imm_i,
  input  logic [DATA_W-1:0] in_base_i,
  input  logic [1:0]        in_mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_ext_o,
  output logic [DATA_W-1:0] out_target_o,
  output logic              out_wrap_o
);

  logic [DATA_W-1:0] new_ext_s, new_tgt_s;
  logic              new_wrap_s;
  logic              accept_s, pop_s;

  logic              r_valid_q, r_valid_d, k_valid_q, k_valid_d;
  logic [DATA_W-1:0] r_ext_q, r_ext_d, r_tgt_q, r_tgt_d;
  logic [DATA_W-1:0] k_ext_q, k_ext_d, k_tgt_q, k_tgt_d;
  logic              r_wrap_q, r_wrap_d, k_wrap_q, k_wrap_d;

  imm_ext_core #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT)
  ) u_core (
    .imm_i   (in_imm_i),
    .base_i  (in_base_i),
    .mode_i  (ext_mode_e'(in_mode_i)),
    .ext_o   (new_ext_s),
    .target_o(new_tgt_s),
    .wrap_o  (new_wrap_s)
  );

  assign accept_s = in_valid_i & ~k_valid_q;
  assign pop_s    = r_valid_q & out_ready_i;

  // Next-state for R/K: K drains into R first so ordering stays FIFO.
  always_comb begin
    r_valid_d = r_valid_q;
    r_ext_d   = r_ext_q;
    r_tgt_d   = r_tgt_q;
    r_wrap_d  = r_wrap_q;
    k_valid_d = k_valid_q;
    k_ext_d   = k_ext_q;
    k_tgt_d   = k_tgt_q;
    k_wrap_d  = k_wrap_q;
    if (flush_i) begin
      // Data is left in place; only the valid bits are dropped.
      r_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (~r_valid_q | pop_s) begin
      if (k_valid_q) begin
        r_valid_d = 1'b1;
        r_ext_d   = k_ext_q;
        r_tgt_d   = k_tgt_q;
        r_wrap_d  = k_wrap_q;
        if (accept_s) begin
          k_valid_d = 1'b1;
          k_ext_d   = new_ext_s;
          k_tgt_d   = new_tgt_s;
          k_wrap_d  = new_wrap_s;
        end else begin
          k_valid_d = 1'b0;
        end
      end else if (accept_s) begin
        r_valid_d = 1'b1;
        r_ext_d   = new_ext_s;
        r_tgt_d   = new_tgt_s;
        r_wrap_d  = new_wrap_s;
      end else begin
        r_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      k_valid_d = 1'b1;
      k_ext_d   = new_ext_s;
      k_tgt_d   = new_tgt_s;
      k_wrap_d  = new_wrap_s;
    end else begin
      k_valid_d = k_valid_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_ext_q   <= {DATA_W{1'b0}};
      r_tgt_q   <= {DATA_W{1'b0}};
      r_wrap_q  <= 1'b0;
      k_valid_q <= 1'b0;
      k_ext_q   <= {DATA_W{1'b0}};
      k_tgt_q   <= {DATA_W{1'b0}};
      k_wrap_q  <= 1'b0;
    end else begin
      r_valid_q <= r_valid_d;
      r_ext_q   <= r_ext_d;
      r_tgt_q   <= r_tgt_d;
      r_wrap_q  <= r_wrap_d;
      k_valid_q <= k_valid_d;
      k_ext_q   <= k_ext_d;
      k_tgt_q   <= k_tgt_d;
      k_wrap_q  <= k_wrap_d;
    end
  end

  assign in_ready_o   = ~k_valid_q;
  assign out_valid_o  = r_valid_q;
  assign out_ext_o    = r_ext_q;
  assign out_target_o = r_tgt_q;
  assign out_wrap_o   = r_wrap_q;

endmodule
